// File: rtl/game_mode_ctrl.sv
// Game-mode sequencer: MENU / INGAME / PAUSE / ENDGAME / LEADERBOARD with level progression and win/lose result.
// All outputs are registered alongside the state and reflect inputs sampled on the previous rising edge.
module game_mode_ctrl #(
    parameter int NUM_LEVELS   = 4,
    parameter int ENDGAME_HOLD = 50000000,
    parameter int HOLD_W       = 26
) (
    input  logic       CLOCK_50,
    input  logic       resetn,
    input  logic       userquit,
    input  logic       keytobegin,
    input  logic       keypause,
    input  logic       levelClear,
    input  logic       gameOver,
    output logic       ingameOn,
    output logic       paused,
    output logic       showLeaderboard,
    output logic       win,
    output logic [3:0] level,
    output logic [3:0] hex0holder
);

    typedef enum logic [2:0] {
        S_MENU    = 3'd0,
        S_INGAME  = 3'd1,
        S_ENDGAME = 3'd2,
        S_PAUSE   = 3'd3,
        S_LEADER  = 3'd4
    } state_t;

    localparam logic [3:0]        LAST_LEVEL = 4'(NUM_LEVELS - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST  = HOLD_W'(ENDGAME_HOLD - 1);

    state_t            state_q, state_d;
    logic [3:0]        level_q, level_d;
    logic              win_q, win_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              prev_begin_q, prev_pause_q;
    logic              ingame_q, paused_q, leader_q;
    logic [3:0]        hex_q;
    logic              begin_rise, pause_rise;

    assign begin_rise = keytobegin & ~prev_begin_q;
    assign pause_rise = keypause & ~prev_pause_q;

    always_comb begin
        state_d = state_q;
        level_d = level_q;
        win_d   = win_q;
        hold_d  = '0;
        if (userquit) begin
            state_d = S_MENU;
            level_d = '0;
            win_d   = 1'b0;
        end else begin
            case (state_q)
                S_MENU: begin
                    if (begin_rise) begin
                        state_d = S_INGAME;
                        level_d = '0;
                        win_d   = 1'b0;
                    end
                end
                S_INGAME: begin
                    if (gameOver) begin
                        state_d = S_ENDGAME;
                        win_d   = 1'b0;
                    end else if (levelClear) begin
                        if (level_q == LAST_LEVEL) begin
                            state_d = S_ENDGAME;
                            win_d   = 1'b1;
                        end else begin
                            level_d = level_q + 4'd1;
                        end
                    end else if (pause_rise) begin
                        state_d = S_PAUSE;
                    end
                end
                S_PAUSE: begin
                    if (pause_rise) begin
                        state_d = S_INGAME;
                    end
                end
                S_ENDGAME: begin
                    // hold_q counts completed ENDGAME cycles; leave on the last one
                    if (hold_q == HOLD_LAST) begin
                        state_d = S_LEADER;
                    end else begin
                        hold_d = hold_q + 1'b1;
                    end
                end
                S_LEADER: begin
                    if (begin_rise) begin
                        state_d = S_MENU;
                        level_d = '0;
                        win_d   = 1'b0;
                    end
                end
                default: begin
                    state_d = S_MENU;
                    level_d = '0;
                    win_d   = 1'b0;
                end
            endcase
        end
    end

    // History registers reset high so a key held through reset needs a fresh press
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            state_q      <= S_MENU;
            level_q      <= '0;
            win_q        <= 1'b0;
            hold_q       <= '0;
            prev_begin_q <= 1'b1;
            prev_pause_q <= 1'b1;
            ingame_q     <= 1'b0;
            paused_q     <= 1'b0;
            leader_q     <= 1'b0;
            hex_q        <= 4'd0;
        end else begin
            state_q      <= state_d;
            level_q      <= level_d;
            win_q        <= win_d;
            hold_q       <= hold_d;
            prev_begin_q <= keytobegin;
            prev_pause_q <= keypause;
            ingame_q     <= (state_d == S_INGAME);
            paused_q     <= (state_d == S_PAUSE);
            leader_q     <= (state_d == S_LEADER);
            hex_q        <= {1'b0, state_d};
        end
    end

    assign ingameOn        = ingame_q;
    assign paused          = paused_q;
    assign showLeaderboard = leader_q;
    assign win             = win_q;
    assign level           = level_q;
    assign hex0holder      = hex_q;

endmodule

// File: tb/tb_game_mode_ctrl.sv
// Bench for game_mode_ctrl: directed scenarios plus random stimulus against a mode-level reference model.
module tb_game_mode_ctrl;

    localparam int NL   = 4;
    localparam int HOLD = 8;

    logic       CLOCK_50 = 1'b0;
    logic       resetn = 1'b0;
    logic       userquit = 1'b0, keytobegin = 1'b0, keypause = 1'b0;
    logic       levelClear = 1'b0, gameOver = 1'b0;
    logic       ingameOn, paused, showLeaderboard, win;
    logic [3:0] level, hex0holder;

    int checks = 0;
    int errors = 0;

    // mode: 0 menu, 1 in game, 2 end game, 3 pause, 4 leaderboard
    int m_mode, m_lvl, m_ticks;
    bit m_win, m_pb, m_pp;

    game_mode_ctrl #(.NUM_LEVELS(NL), .ENDGAME_HOLD(HOLD), .HOLD_W(4)) dut (
        .CLOCK_50(CLOCK_50), .resetn(resetn), .userquit(userquit),
        .keytobegin(keytobegin), .keypause(keypause),
        .levelClear(levelClear), .gameOver(gameOver),
        .ingameOn(ingameOn), .paused(paused), .showLeaderboard(showLeaderboard),
        .win(win), .level(level), .hex0holder(hex0holder)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    function automatic logic [11:0] act();
        return {ingameOn, paused, showLeaderboard, win, level, hex0holder};
    endfunction

    function automatic logic [11:0] expv();
        logic i, p, l;
        i = (m_mode == 1);
        p = (m_mode == 3);
        l = (m_mode == 4);
        return {i, p, l, m_win, 4'(m_lvl), 4'(m_mode)};
    endfunction

    task automatic model_reset();
        m_mode = 0; m_lvl = 0; m_win = 0; m_ticks = 0; m_pb = 1; m_pp = 1;
    endtask

    task automatic model_step();
        bit br, pr;
        br = keytobegin && !m_pb;
        pr = keypause && !m_pp;
        if (userquit) begin
            m_mode = 0; m_lvl = 0; m_win = 0;
        end else if (m_mode == 0) begin
            if (br) begin m_mode = 1; m_lvl = 0; m_win = 0; end
        end else if (m_mode == 1) begin
            if (gameOver) begin m_mode = 2; m_win = 0; m_ticks = 0; end
            else if (levelClear) begin
                if (m_lvl == NL - 1) begin m_mode = 2; m_win = 1; m_ticks = 0; end
                else m_lvl++;
            end else if (pr) m_mode = 3;
        end else if (m_mode == 3) begin
            if (pr) m_mode = 1;
        end else if (m_mode == 2) begin
            m_ticks++;
            if (m_ticks == HOLD) m_mode = 4;
        end else if (m_mode == 4) begin
            if (br) begin m_mode = 0; m_lvl = 0; m_win = 0; end
        end
        m_pb = keytobegin;
        m_pp = keypause;
    endtask

    task automatic step();
        model_step();
        @(posedge CLOCK_50);
        #1;
    endtask

    task automatic start_game();
        keytobegin = 0; step();
        keytobegin = 1; step();
    endtask

    task automatic test_reset();
        resetn = 0; keytobegin = 1;
        model_reset();
        #12;
        checks++;
        if (act() !== 12'h000) begin
            errors++; $display("FAIL reset_state: got %h want %h", act(), 12'h000);
        end
        @(negedge CLOCK_50); resetn = 1;
        repeat (3) step();
        checks++;
        if (hex0holder !== 4'd0 || act() !== expv()) begin
            errors++; $display("FAIL held_begin_ignored: got %h want %h", act(), expv());
        end
        keytobegin = 0; step();
        keytobegin = 1; step();
        checks++;
        if (ingameOn !== 1'b1 || hex0holder !== 4'd1 || level !== 4'd0 || act() !== expv()) begin
            errors++; $display("FAIL start_ingame: got %h want %h", act(), expv());
        end
    endtask

    task automatic test_win_path();
        for (int i = 0; i < NL; i++) begin
            levelClear = 1; step(); levelClear = 0;
            checks++;
            if (i < NL - 1) begin
                if (hex0holder !== 4'd1 || level !== 4'(i + 1) || act() !== expv()) begin
                    errors++; $display("FAIL level_advance_%0d: got %h want %h", i, act(), expv());
                end
            end else if (hex0holder !== 4'd2 || win !== 1'b1 || level !== 4'(NL - 1) || act() !== expv()) begin
                errors++; $display("FAIL win_endgame: got %h want %h", act(), expv());
            end
        end
        for (int j = 0; j < HOLD - 1; j++) begin
            step();
            checks++;
            if (hex0holder !== 4'd2 || act() !== expv()) begin
                errors++; $display("FAIL endgame_hold_%0d: got %h want %h", j, act(), expv());
            end
        end
        step();
        checks++;
        if (showLeaderboard !== 1'b1 || hex0holder !== 4'd4 || win !== 1'b1 || act() !== expv()) begin
            errors++; $display("FAIL leaderboard_entry: got %h want %h", act(), expv());
        end
        keytobegin = 0; step();
        keytobegin = 1; step();
        checks++;
        if (hex0holder !== 4'd0 || act() !== expv()) begin
            errors++; $display("FAIL leaderboard_exit: got %h want %h", act(), expv());
        end
    endtask

    task automatic test_pause();
        start_game();
        levelClear = 1; step(); levelClear = 0;
        keypause = 1; step();
        checks++;
        if (paused !== 1'b1 || ingameOn !== 1'b0 || hex0holder !== 4'd3 || act() !== expv()) begin
            errors++; $display("FAIL pause_entry: got %h want %h", act(), expv());
        end
        keypause = 0;
        levelClear = 1; step(); levelClear = 0;
        gameOver = 1; step(); gameOver = 0;
        checks++;
        if (hex0holder !== 4'd3 || level !== 4'd1 || act() !== expv()) begin
            errors++; $display("FAIL pause_frozen: got %h want %h", act(), expv());
        end
        keypause = 1; step();
        checks++;
        if (hex0holder !== 4'd1 || level !== 4'd1 || act() !== expv()) begin
            errors++; $display("FAIL pause_exit: got %h want %h", act(), expv());
        end
        keypause = 0; step();
    endtask

    task automatic test_loss_collision();
        levelClear = 1; gameOver = 1; step(); levelClear = 0; gameOver = 0;
        checks++;
        if (hex0holder !== 4'd2 || win !== 1'b0 || level !== 4'd1 || act() !== expv()) begin
            errors++; $display("FAIL loss_collision: got %h want %h", act(), expv());
        end
    endtask

    task automatic test_quit();
        repeat (3) step();
        userquit = 1; step(); userquit = 0;
        checks++;
        if (act() !== 12'h000 || act() !== expv()) begin
            errors++; $display("FAIL quit_endgame: got %h want %h", act(), expv());
        end
        start_game();
        keypause = 0; step();
        keypause = 1; step();
        userquit = 1; step(); userquit = 0;
        checks++;
        if (act() !== 12'h000 || act() !== expv()) begin
            errors++; $display("FAIL quit_pause: got %h want %h", act(), expv());
        end
        keypause = 0;
        start_game();
        gameOver = 1; step(); gameOver = 0;
        repeat (HOLD) step();
        checks++;
        if (hex0holder !== 4'd4 || act() !== expv()) begin
            errors++; $display("FAIL loss_leaderboard: got %h want %h", act(), expv());
        end
        userquit = 1; step(); userquit = 0;
        checks++;
        if (act() !== 12'h000 || act() !== expv()) begin
            errors++; $display("FAIL quit_leaderboard: got %h want %h", act(), expv());
        end
    endtask

    task automatic test_async_reset();
        start_game();
        levelClear = 1; step(); step(); levelClear = 0;
        checks++;
        if (level !== 4'd2 || act() !== expv()) begin
            errors++; $display("FAIL pre_reset_level: got %h want %h", act(), expv());
        end
        #2 resetn = 0;
        model_reset();
        #1;
        checks++;
        if (act() !== 12'h000) begin
            errors++; $display("FAIL async_reset: got %h want %h", act(), 12'h000);
        end
        @(negedge CLOCK_50); resetn = 1;
        step(); step();
        checks++;
        if (hex0holder !== 4'd0 || act() !== expv()) begin
            errors++; $display("FAIL reset_held_begin: got %h want %h", act(), expv());
        end
        start_game();
        checks++;
        if (hex0holder !== 4'd1 || act() !== expv()) begin
            errors++; $display("FAIL reset_fresh_press: got %h want %h", act(), expv());
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 800; n++) begin
            userquit   = ($urandom_range(0, 59) == 0);
            gameOver   = ($urandom_range(0, 39) == 0);
            levelClear = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 3) == 0) keytobegin = ~keytobegin;
            if ($urandom_range(0, 4) == 0) keypause = ~keypause;
            step();
            checks++;
            if (act() !== expv()) begin
                errors++; $display("FAIL random_%0d: got %h want %h", n, act(), expv());
            end
        end
        userquit = 0; gameOver = 0; levelClear = 0;
    endtask

    initial begin
        test_reset();
        test_win_path();
        test_pause();
        test_loss_collision();
        test_quit();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
